// File: rtl/ccip_req_skid_pipe.sv
// Per-channel request pipeline with skid FIFO for the CCI-P Tx path.
// Almost-full to the AFU is regenerated locally so the added depth and the AFU's reaction time cannot overflow.
module ccip_req_skid_pipe #(
   parameter int NUM_CHAN    = 3,
   parameter int DATA_W      = 640,
   parameter int PIPE_STAGES = 2,
   parameter int SKID_DEPTH  = 16,
   parameter int UP_LAT      = 4
) (
   input  logic                       pClk,
   input  logic                       SoftReset_n,
   input  logic [NUM_CHAN-1:0]        up_valid,
   input  logic [NUM_CHAN*DATA_W-1:0] up_data,
   output logic [NUM_CHAN-1:0]        up_almfull,
   input  logic [NUM_CHAN-1:0]        dn_almfull,
   output logic [NUM_CHAN-1:0]        dn_valid,
   output logic [NUM_CHAN*DATA_W-1:0] dn_data,
   input  logic                       clr_err,
   output logic [NUM_CHAN-1:0]        ovf_sticky,
   output logic [15:0]                drop_cnt
);

   localparam int PTR_W = $clog2(SKID_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int INF_W = $clog2(PIPE_STAGES + 1);
   localparam int SUM_W = CNT_W + 2;
   localparam logic [SUM_W-1:0] AF_THRESH = SUM_W'(SKID_DEPTH - UP_LAT - 1);

   logic [NUM_CHAN-1:0] drop_vec;
   logic [15:0]         n_drops;
   logic [15:0]         drop_base;
   logic [16:0]         drop_sum;

   for (genvar c = 0; c < NUM_CHAN; c++) begin : g_chan
      logic [PIPE_STAGES-1:0] pipe_v;
      logic [DATA_W-1:0]      pipe_d [PIPE_STAGES];
      logic [DATA_W-1:0]      mem [SKID_DEPTH];
      logic [PTR_W-1:0]       wr_ptr;
      logic [PTR_W-1:0]       rd_ptr;
      logic [CNT_W-1:0]       cnt;
      logic [INF_W-1:0]       inflight;
      logic [SUM_W-1:0]       occupancy;
      logic                   push;
      logic                   pop;
      logic                   full;
      logic                   drop;
      logic                   do_write;
      logic                   dn_valid_q;
      logic                   up_almfull_q;
      logic [DATA_W-1:0]      dn_data_q;

      // Only the valid bits are reset; payload registers just follow along.
      always_ff @(posedge pClk or negedge SoftReset_n) begin
         if (!SoftReset_n) begin
            pipe_v <= '0;
         end else begin
            pipe_v[0] <= up_valid[c];
            for (int i = 1; i < PIPE_STAGES; i++) begin
               pipe_v[i] <= pipe_v[i-1];
            end
         end
      end

      always_ff @(posedge pClk) begin
         pipe_d[0] <= up_data[c*DATA_W +: DATA_W];
         for (int i = 1; i < PIPE_STAGES; i++) begin
            pipe_d[i] <= pipe_d[i-1];
         end
      end

      always_comb begin
         inflight = '0;
         for (int i = 0; i < PIPE_STAGES; i++) begin
            inflight = inflight + INF_W'(pipe_v[i]);
         end
      end

      // A push into a full FIFO survives only if the same edge pops a slot.
      assign push      = pipe_v[PIPE_STAGES-1];
      assign pop       = (cnt != '0) && !dn_almfull[c];
      assign full      = (cnt == CNT_W'(SKID_DEPTH));
      assign drop      = push && full && !pop;
      assign do_write  = push && !drop;
      assign occupancy = SUM_W'(cnt) + SUM_W'(inflight);

      always_ff @(posedge pClk) begin
         if (do_write) begin
            mem[wr_ptr] <= pipe_d[PIPE_STAGES-1];
         end
         if (pop) begin
            dn_data_q <= mem[rd_ptr];
         end
      end

      always_ff @(posedge pClk or negedge SoftReset_n) begin
         if (!SoftReset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            cnt          <= '0;
            dn_valid_q   <= 1'b0;
            up_almfull_q <= 1'b1;
         end else begin
            if (do_write) begin
               wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
               rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, pop})
               2'b10:   cnt <= cnt + 1'b1;
               2'b01:   cnt <= cnt - 1'b1;
               default: cnt <= cnt;
            endcase
            dn_valid_q   <= pop;
            up_almfull_q <= (occupancy >= AF_THRESH);
         end
      end

      assign dn_valid[c]                   = dn_valid_q;
      assign dn_data[c*DATA_W +: DATA_W]   = dn_data_q;
      assign up_almfull[c]                 = up_almfull_q;
      assign drop_vec[c]                   = drop;
   end

   always_comb begin
      n_drops = '0;
      for (int c = 0; c < NUM_CHAN; c++) begin
         n_drops = n_drops + 16'(drop_vec[c]);
      end
   end

   // A drop in the same cycle as clr_err is still recorded.
   assign drop_base = clr_err ? 16'h0000 : drop_cnt;
   assign drop_sum  = {1'b0, drop_base} + {1'b0, n_drops};

   always_ff @(posedge pClk or negedge SoftReset_n) begin
      if (!SoftReset_n) begin
         ovf_sticky <= '0;
         drop_cnt   <= '0;
      end else begin
         ovf_sticky <= (clr_err ? '0 : ovf_sticky) | drop_vec;
         drop_cnt   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

endmodule

// File: tb/tb_ccip_req_skid_pipe.sv
// Scoreboard bench for ccip_req_skid_pipe: a queue-based model predicts every dn_valid pulse with its cycle and payload.
module tb_ccip_req_skid_pipe;

   localparam int NC = 3;
   localparam int DW = 640;
   localparam int PS = 2;
   localparam int SD = 16;
   localparam int UL = 4;

   typedef logic [DW-1:0] data_t;
   typedef struct { bit v; data_t d; } slot_t;
   typedef struct { int cyc; data_t d; } exp_t;

   logic             pClk = 1'b0;
   logic             SoftReset_n = 1'b1;
   logic [NC-1:0]    up_valid;
   logic [NC*DW-1:0] up_data;
   logic [NC-1:0]    up_almfull;
   logic [NC-1:0]    dn_almfull;
   logic [NC-1:0]    dn_valid;
   logic [NC*DW-1:0] dn_data;
   logic             clr_err;
   logic [NC-1:0]    ovf_sticky;
   logic [15:0]      drop_cnt;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   slot_t pipe_q [NC][$];
   data_t fifo_q [NC][$];
   exp_t  exp_q  [NC][$];
   logic [NC-1:0] exp_af;
   logic [NC-1:0] exp_sticky;
   int exp_drop;
   int budget [NC];

   ccip_req_skid_pipe #(
      .NUM_CHAN(NC), .DATA_W(DW), .PIPE_STAGES(PS), .SKID_DEPTH(SD), .UP_LAT(UL)
   ) dut (
      .pClk(pClk), .SoftReset_n(SoftReset_n),
      .up_valid(up_valid), .up_data(up_data), .up_almfull(up_almfull),
      .dn_almfull(dn_almfull), .dn_valid(dn_valid), .dn_data(dn_data),
      .clr_err(clr_err), .ovf_sticky(ovf_sticky), .drop_cnt(drop_cnt)
   );

   initial forever #5 pClk = ~pClk;

   function automatic void check_output(string name, data_t act, data_t req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endfunction

   function automatic data_t rand_data();
      data_t d;
      for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic model_reset();
      slot_t s;
      s.v = 1'b0;
      s.d = '0;
      for (int c = 0; c < NC; c++) begin
         pipe_q[c].delete();
         fifo_q[c].delete();
         exp_q[c].delete();
         for (int i = 0; i < PS; i++) pipe_q[c].push_back(s);
      end
      exp_af     = '1;
      exp_sticky = '0;
      exp_drop   = 0;
   endtask

   // One clock of the reference: pipe is a PS-deep delay queue, the FIFO an SD-bounded queue.
   task automatic model_step();
      logic [NC-1:0] dropped;
      int ndrop;
      dropped = '0;
      ndrop   = 0;
      for (int c = 0; c < NC; c++) begin
         slot_t last;
         slot_t nxt;
         exp_t  e;
         int    occ;
         occ = fifo_q[c].size();
         for (int i = 0; i < pipe_q[c].size(); i++) if (pipe_q[c][i].v) occ++;
         exp_af[c] = (occ >= SD - UL - 1);
         last = pipe_q[c].pop_front();
         if (fifo_q[c].size() != 0 && !dn_almfull[c]) begin
            e.cyc = cyc;
            e.d   = fifo_q[c].pop_front();
            exp_q[c].push_back(e);
         end
         if (last.v) begin
            if (fifo_q[c].size() < SD) fifo_q[c].push_back(last.d);
            else begin
               dropped[c] = 1'b1;
               ndrop++;
            end
         end
         nxt.v = up_valid[c];
         nxt.d = up_data[c*DW +: DW];
         pipe_q[c].push_back(nxt);
      end
      exp_sticky = (clr_err ? '0 : exp_sticky) | dropped;
      exp_drop   = (clr_err ? 0 : exp_drop) + ndrop;
      if (exp_drop > 65535) exp_drop = 65535;
   endtask

   initial forever begin
      @(posedge pClk);
      cyc++;
      if (!SoftReset_n) model_reset();
      else model_step();
   end

   // Monitor: every dn_valid pulse must match the front of its channel's queue, in the predicted cycle.
   initial forever begin
      @(negedge pClk);
      for (int c = 0; c < NC; c++) begin
         logic due;
         exp_t e;
         due = (exp_q[c].size() != 0) && (exp_q[c][0].cyc == cyc);
         check_output($sformatf("dn_valid[%0d]", c), DW'(dn_valid[c]), DW'(due));
         if (due) begin
            e = exp_q[c].pop_front();
            if (dn_valid[c]) check_output($sformatf("dn_data[%0d]", c), dn_data[c*DW +: DW], e.d);
         end
      end
      check_output("up_almfull", DW'(up_almfull), DW'(exp_af));
      check_output("ovf_sticky", DW'(ovf_sticky), DW'(exp_sticky));
      check_output("drop_cnt", DW'(drop_cnt), DW'(exp_drop));
   end

   task automatic cycle();
      @(posedge pClk);
      #1;
      up_valid = '0;
      clr_err  = 1'b0;
   endtask

   // AFU behaviour: after seeing up_almfull high it may issue at most UL more requests.
   task automatic apply_stimulus(input int c, input bit want, input bit force_issue);
      if (!up_almfull[c]) budget[c] = UL;
      if (want && (budget[c] > 0 || force_issue)) begin
         up_valid[c] = 1'b1;
         up_data[c*DW +: DW] = rand_data();
         if (up_almfull[c] && budget[c] > 0) budget[c]--;
      end
   endtask

   task automatic check_reset_values(string tag);
      check_output({tag, "_dn_valid"}, DW'(dn_valid), DW'(0));
      check_output({tag, "_up_almfull"}, DW'(up_almfull), DW'(3'b111));
      check_output({tag, "_ovf_sticky"}, DW'(ovf_sticky), DW'(0));
      check_output({tag, "_drop_cnt"}, DW'(drop_cnt), DW'(0));
   endtask

   initial begin
      int k;
      up_valid   = '0;
      up_data    = '0;
      dn_almfull = '0;
      clr_err    = 1'b0;
      for (int c = 0; c < NC; c++) budget[c] = UL;
      #1;
      SoftReset_n = 1'b0;
      model_reset();

      // Reset, release, single request latency on channel 1
      repeat (5) cycle();
      check_reset_values("reset");
      SoftReset_n = 1'b1;
      cycle();
      check_output("almfull_after_release", DW'(up_almfull), DW'(0));
      repeat (3) cycle();
      up_valid[1] = 1'b1;
      up_data[DW +: DW] = DW'(8'hA5);
      cycle();
      repeat (PS) cycle();
      check_output("latency_early", DW'(dn_valid), DW'(0));
      cycle();
      check_output("latency_valid", DW'(dn_valid), DW'(3'b010));
      check_output("latency_data", dn_data[DW +: DW], DW'(8'hA5));

      // Back-pressure with an AFU honouring UL
      dn_almfull = 3'b001;
      for (int i = 0; i < 40; i++) begin
         apply_stimulus(0, 1'b1, 1'b0);
         cycle();
      end
      repeat (PS + 1) cycle();
      check_output("bp_sticky", DW'(ovf_sticky), DW'(0));
      check_output("bp_drop", DW'(drop_cnt), DW'(0));
      check_output("bp_almfull", DW'(up_almfull[0]), DW'(1));
      dn_almfull = '0;
      repeat (25) cycle();

      // Drain order on channel 2
      dn_almfull = 3'b100;
      for (int v = 0; v < 16; v++) begin
         up_valid[2] = 1'b1;
         up_data[2*DW +: DW] = DW'(v);
         cycle();
      end
      repeat (PS + 1) cycle();
      check_output("fill_almfull", DW'(up_almfull[2]), DW'(1));
      dn_almfull = '0;
      k = 0;
      repeat (24) begin
         cycle();
         if (dn_valid[2]) begin
            check_output("drain_value", dn_data[2*DW +: DW], DW'(k));
            k++;
         end
      end
      check_output("drain_count", DW'(k), DW'(16));
      check_output("drain_almfull", DW'(up_almfull[2]), DW'(0));

      // Overflow on channel 0: 3 extra pushes into a full FIFO
      dn_almfull = 3'b001;
      for (int v = 0; v < 19; v++) begin
         up_valid[0] = 1'b1;
         up_data[0 +: DW] = DW'(100 + v);
         cycle();
      end
      repeat (PS + 1) cycle();
      check_output("ovf_sticky", DW'(ovf_sticky), DW'(3'b001));
      check_output("ovf_drop_cnt", DW'(drop_cnt), DW'(3));

      // Clear colliding with drops on channels 1 and 2
      dn_almfull = 3'b111;
      for (int v = 0; v < 16; v++) begin
         up_valid = 3'b110;
         up_data[DW +: DW] = DW'(200 + v);
         up_data[2*DW +: DW] = DW'(300 + v);
         cycle();
      end
      repeat (PS + 1) cycle();
      up_valid = 3'b110;
      cycle();
      cycle();
      clr_err = 1'b1;
      cycle();
      check_output("collide_sticky", DW'(ovf_sticky), DW'(3'b110));
      check_output("collide_drop_cnt", DW'(drop_cnt), DW'(2));
      clr_err = 1'b1;
      cycle();
      check_output("clear_sticky", DW'(ovf_sticky), DW'(0));
      check_output("clear_drop_cnt", DW'(drop_cnt), DW'(0));

      // Full channel 0: push and pop on the same edge
      up_valid[0] = 1'b1;
      up_data[0 +: DW] = DW'(16'h777);
      cycle();
      cycle();
      dn_almfull[0] = 1'b0;
      cycle();
      dn_almfull[0] = 1'b1;
      check_output("full_pp_valid", DW'(dn_valid[0]), DW'(1));
      check_output("full_pp_data", dn_data[0 +: DW], DW'(100));
      check_output("full_pp_drop", DW'(drop_cnt), DW'(0));
      check_output("full_pp_sticky", DW'(ovf_sticky), DW'(0));
      cycle();
      check_output("full_pp_single", DW'(dn_valid[0]), DW'(0));
      dn_almfull = '0;
      repeat (40) cycle();

      // Randomised traffic with bursty back-pressure and one mid-run reset
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) begin
            SoftReset_n = 1'b0;
            model_reset();
            #1;
            check_reset_values("midreset");
            for (int c = 0; c < NC; c++) budget[c] = UL;
            repeat (3) cycle();
            SoftReset_n = 1'b1;
         end
         for (int c = 0; c < NC; c++) begin
            if ($urandom_range(9) == 0) dn_almfull[c] = ~dn_almfull[c];
            apply_stimulus(c, $urandom_range(99) < 60, $urandom_range(199) == 0);
         end
         clr_err = ($urandom_range(49) == 0);
         cycle();
      end

      up_valid   = '0;
      dn_almfull = '0;
      repeat (40) cycle();
      for (int c = 0; c < NC; c++) begin
         check_output($sformatf("sb_empty[%0d]", c), DW'(exp_q[c].size()), DW'(0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
